hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard/scheduling controller for the 5-stage MiniMIPS pipeline.
- Tracks in-flight destination registers for the E, M and W stages in internal shadow registers.
- Generates fetch/decode stalls, decode/execute flushes, decode-stage branch-compare forwarding (ForwardAD/BD) and execute-stage operand forwarding.
- Sits beside DecodeStage and consumes the decoded control of the instruction in D.

Parameters:
- REG_AW, 5, register address width.
- FWD_W, 2, execute-forward select width.

Ports:
- CLK  input  1  pipeline clock.
- RST  input  1  asynchronous active-low reset.
- RsD  input  REG_AW  source register A of the D instruction.
- RtD  input  REG_AW  source register B of the D instruction.
- WriteRegD  input  REG_AW  destination of the D instruction, after RegDst selection.
- RegWriteD  input  1  D instruction writes the register file.
- MemtoRegD  input  1  D instruction is a load.
- BranchD  input  1  D instruction is beq.
- JumpD  input  1  D instruction is j.
- PCSrcD  input  1  branch taken (BranchD & EqualD).
- StallF  output  1  hold PC.
- StallD  output  1  hold the IF/ID register.
- FlushD  output  1  clear the IF/ID register.
- FlushE  output  1  clear the ID/EX register (insert bubble).
- ForwardAD  output  1  RD1 comparator input selects ALUOutM.
- ForwardBD  output  1  RD2 comparator input selects ALUOutM.
- ForwardAE  output  FWD_W  ALU A source: 00 register file, 01 ResultW, 10 ALUOutM.
- ForwardBE  output  FWD_W  ALU B source, same encoding as ForwardAE.

Behaviour:
- Tracker registers:
  - E stage: RsE, RtE, WriteRegE, RegWriteE, MemtoRegE.
  - M stage: WriteRegM, RegWriteM, MemtoRegM.
  - W stage: WriteRegW, RegWriteW.
- On each rising CLK:
  - E loads the D inputs, or a bubble (all fields 0) when FlushE=1.
  - M loads E.
  - W loads M.
- Reset: RST low clears all trackers to 0 asynchronously, and every output is forced 0 while RST is low. The first edge after deassertion behaves normally.
- Register 0 never matches: every compare is qualified by address != 0.
- ForwardAE:
  - 10 if RsE==WriteRegM & RegWriteM.
  - else 01 if RsE==WriteRegW & RegWriteW.
  - else 00.
  - M has priority when M and W both match.
- ForwardBE: same rules as ForwardAE, using RtE.
- ForwardAD = RsD==WriteRegM & RegWriteM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM∈{RsD,RtD})).
- StallF = StallD = FlushE = lwstall | branchstall.
  - All are combinational: zero added latency, valid in the same cycle.
  - A load-use dependency stalls 1 cycle; beq after an ALU op stalls 1 cycle; beq after a load stalls 2 cycles.
- FlushD = (PCSrcD | JumpD) & ~StallD.
  - A taken branch or jump under stall does not flush until the stall clears.
- Simultaneous stall and flush: the stall wins for D; FlushE still inserts the bubble.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt[31:0]: increments each cycle StallD=1.
  - flush_cnt[31:0]: increments each cycle FlushD=1.
  - Both are cleared by RST and wrap at 2^32-1 -> 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mips_hazard_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_AW;
  - a packed stage-tracker struct typedef.
- Sub-module hazard_fwd_sel computes one execute-forward select from (src, WriteRegM, RegWriteM, WriteRegW, RegWriteW). It is instantiated twice, for A and B.

Test Plan:
- add $3 followed by sub using RsD=3: the next cycle ForwardAE=10; one cycle later, with the dependent advanced, ForwardAE=01 for an instruction reading $3.
- lw $5 in E (MemtoRegE=1, RtE=5), RsD=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle, then ForwardAE=01 when the dependent reaches E.
- add $4 in E, beq with RsD=4 -> 1 stall cycle, then ForwardAD=1 with no stall; lw $4 then beq on $4 -> 2 stall cycles.
- JumpD=1 with no hazard -> FlushD=1 in that cycle; PCSrcD=1 during branchstall -> FlushD=0 until the stall clears, then 1.
- WriteRegM=0, RegWriteM=1, RsE=0, RsD=0 -> ForwardAE=00 and ForwardAD=0.
- RST driven low mid-lwstall -> all outputs 0 immediately; after release, with no new hazard inputs, the trackers read 0 and StallD=0.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MiniMIPS hazard controller.
package mips_hazard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wreg;
    logic              reg_write;
    logic              mem_to_reg;
  } trk_e_t;

  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic              reg_write;
    logic              mem_to_reg;
  } trk_m_t;

  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic              reg_write;
  } trk_w_t;

  // $0 is hardwired, so it can never be a real dependency.
  function automatic logic reg_hit(input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Execute-stage forward select for one ALU operand; M beats W when both match.
module hazard_fwd_sel
  import mips_hazard_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              regwrite_w,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && reg_hit(src, wreg_m)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && reg_hit(src, wreg_w)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// MiniMIPS hazard controller: stalls, flushes and forwarding from shadow E/M/W trackers.
// Optional HAZARD_PERF_EN adds free-running stall/flush cycle counters.
module hazard_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int REG_AW = mips_hazard_pkg::REG_AW,
  parameter int FWD_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              PCSrcD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [FWD_W-1:0]  ForwardAE,
  output logic [FWD_W-1:0]  ForwardBE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  trk_e_t e_q;
  trk_m_t m_q;
  trk_w_t w_q;

  logic       lwstall;
  logic       branchstall;
  logic       stall;
  logic       flush_d;
  logic       fwd_ad;
  logic       fwd_bd;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  always_comb begin
    lwstall = e_q.mem_to_reg &
              (reg_hit(e_q.rt, RsD) | reg_hit(e_q.rt, RtD));
    // A beq resolves in D, so it must wait for an ALU result still in E
    // or a load result still in M.
    branchstall = BranchD &
                  ((e_q.reg_write  & (reg_hit(e_q.wreg, RsD) | reg_hit(e_q.wreg, RtD))) |
                   (m_q.mem_to_reg & (reg_hit(m_q.wreg, RsD) | reg_hit(m_q.wreg, RtD))));
    stall   = lwstall | branchstall;
    flush_d = (PCSrcD | JumpD) & ~stall;
    fwd_ad  = m_q.reg_write & reg_hit(m_q.wreg, RsD);
    fwd_bd  = m_q.reg_write & reg_hit(m_q.wreg, RtD);
  end

  hazard_fwd_sel u_fwd_a (
    .src        (e_q.rs),
    .wreg_m     (m_q.wreg),
    .regwrite_m (m_q.reg_write),
    .wreg_w     (w_q.wreg),
    .regwrite_w (w_q.reg_write),
    .sel        (fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .src        (e_q.rt),
    .wreg_m     (m_q.wreg),
    .regwrite_m (m_q.reg_write),
    .wreg_w     (w_q.wreg),
    .regwrite_w (w_q.reg_write),
    .sel        (fwd_b)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (stall) begin
        e_q <= '0;
      end else begin
        e_q <= '{rs: RsD, rt: RtD, wreg: WriteRegD,
                 reg_write: RegWriteD, mem_to_reg: MemtoRegD};
      end
      m_q <= '{wreg: e_q.wreg, reg_write: e_q.reg_write, mem_to_reg: e_q.mem_to_reg};
      w_q <= '{wreg: m_q.wreg, reg_write: m_q.reg_write};
    end
  end

  // Outputs are held low for the whole reset window, not just until the first edge.
  always_comb begin
    StallF    = RST & stall;
    StallD    = RST & stall;
    FlushE    = RST & stall;
    FlushD    = RST & flush_d;
    ForwardAD = RST & fwd_ad;
    ForwardBD = RST & fwd_bd;
    ForwardAE = RST ? FWD_W'(fwd_a) : '0;
    ForwardBE = RST ? FWD_W'(fwd_b) : '0;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)   stall_cnt <= stall_cnt + 32'd1;
      if (flush_d) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations per cycle.
module tb_hazard_ctrl;

  logic       CLK;
  logic       RST;
  logic [4:0] RsD, RtD, WriteRegD;
  logic       RegWriteD, MemtoRegD, BranchD, JumpD, PCSrcD;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .RsD       (RsD),
    .RtD       (RtD),
    .WriteRegD (WriteRegD),
    .RegWriteD (RegWriteD),
    .MemtoRegD (MemtoRegD),
    .BranchD   (BranchD),
    .JumpD     (JumpD),
    .PCSrcD    (PCSrcD),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic br,
                       input logic j, input logic pc);
    RsD = rs; RtD = rt; WriteRegD = wr;
    RegWriteD = rw; MemtoRegD = mr; BranchD = br; JumpD = j; PCSrcD = pc;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Vector order: StallF StallD FlushD FlushE ForwardAD ForwardBD ForwardAE ForwardBE
  task automatic expect_out(input string tag, input logic st, input logic fd,
                            input logic ad, input logic bd,
                            input logic [1:0] ae, input logic [1:0] be);
    logic [9:0] obs, exp;
    obs = {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE};
    exp = {st, st, fd, st, ad, bd, ae, be};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  initial begin
    RST = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(); cyc();
    #1 expect_out("rst_forced_zero", 0, 0, 0, 0, 2'b00, 2'b00);
    RST = 1'b1;

    // add $3 ; sub $6,$3,$4 ; or $7,$3,$0
    drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("add3_in_d", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    drive(5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("sub_in_d", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    drive(5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("fwd_ae_mem", 0, 0, 1, 0, 2'b10, 2'b00);
    cyc();
    nop();
    #1 expect_out("fwd_ae_wb", 0, 0, 0, 0, 2'b01, 2'b00);
    drain();

    // M beats W: two writers of $9, then a reader of $9 on both operands
    drive(5'd1, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd1, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd9, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("fwd_ad_bd", 0, 0, 1, 1, 2'b00, 2'b00);
    cyc();
    nop();
    #1 expect_out("fwd_m_priority", 0, 0, 0, 0, 2'b10, 2'b10);
    drain();

    // lw $5 ; add $8,$5,$2
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 expect_out("lw5_in_d", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    drive(5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("lwstall_on", 1, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    #1 expect_out("lwstall_released", 0, 0, 1, 0, 2'b00, 2'b00);
    cyc();
    nop();
    #1 expect_out("lw_use_fwd_wb", 0, 0, 0, 0, 2'b01, 2'b00);
    drain();

    // add $4 ; beq $4,$0
    drive(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 expect_out("beq_alu_stall", 1, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    #1 expect_out("beq_alu_fwd_ad", 0, 0, 1, 0, 2'b00, 2'b00);
    cyc();
    drain();

    // lw $4 ; beq $4 taken: two stall cycles, flush held off until stall clears
    drive(5'd1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 expect_out("beq_lw_stall1", 1, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    #1 expect_out("beq_lw_stall2", 1, 0, 1, 0, 2'b00, 2'b00);
    cyc();
    #1 expect_out("beq_lw_flush", 0, 1, 0, 0, 2'b00, 2'b00);
    cyc();
    drain();

    // jump, no hazard
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 expect_out("jump_flush", 0, 1, 0, 0, 2'b00, 2'b00);
    cyc();
    drain();

    // $0 never matches: load to $0, ALU write to $0, beq on $0
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("r0_no_lwstall", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 expect_out("r0_no_fwd_no_bstall", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    drain();

    // reset asserted in the middle of a load-use stall
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    drive(5'd5, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 expect_out("pre_rst_stall", 1, 0, 0, 0, 2'b00, 2'b00);
    RST = 1'b0;
    #1 expect_out("rst_async_zero", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc(); cyc();
    RST = 1'b1;
    #1 expect_out("post_rst_clear", 0, 0, 0, 0, 2'b00, 2'b00);
    cyc();
    drive(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 expect_out("post_rst_first_edge", 1, 0, 0, 0, 2'b00, 2'b00);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
